// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// and the load/store stage. Data accesses win arbitration, but only for a
// bounded run of grants while fetch is waiting, so fetch always progresses.
// Each access runs as a req/ack handshake on registered mem_* outputs, with a
// busy-cycle watchdog that aborts a stuck access and raises a sticky bus_err.
module mem_port_arbiter #(
    parameter int unsigned MAX_DATA_BURST = 4,
    parameter int unsigned TIMEOUT        = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall_f,
    output logic        stall_m,
    output logic        bus_err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_D_BUSY = 2'd1;
    localparam logic [1:0] ST_F_BUSY = 2'd2;

    // Data may keep winning while fetch waits until the streak reaches this.
    localparam logic [3:0] BURST_LIM = 4'(MAX_DATA_BURST);
    // wait_cnt counts completed busy cycles, so the last allowed busy cycle
    // is the one where it equals TIMEOUT-1.
    localparam logic [7:0] WAIT_LIM  = 8'(TIMEOUT - 32'd1);

    logic [1:0]  state_q,     state_d;
    logic        mem_req_q,   mem_req_d;
    logic        mem_we_q,    mem_we_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] if_rdata_q,  if_rdata_d;
    logic [31:0] d_rdata_q,   d_rdata_d;
    logic        if_valid_q,  if_valid_d;
    logic        d_valid_q,   d_valid_d;
    logic        bus_err_q,   bus_err_d;
    logic [3:0]  streak_q,    streak_d;
    logic [7:0]  wait_cnt_q,  wait_cnt_d;

    logic        grant_data_s;
    logic        owner_data_s;

    assign grant_data_s = d_req & (~if_req | (streak_q < BURST_LIM));
    assign owner_data_s = (state_q == ST_D_BUSY);

    // Next-state logic: arbitration in IDLE, completion/abort in BUSY.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        bus_err_d   = bus_err_q;
        streak_d    = streak_q;
        wait_cnt_d  = wait_cnt_q;

        case (state_q)
            ST_IDLE: begin
                wait_cnt_d = 8'd0;
                if (grant_data_s) begin
                    state_d     = ST_D_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_wstrb_d = d_we ? d_wstrb : 4'd0;
                    streak_d    = if_req ? (streak_q + 4'd1) : 4'd0;
                end else if (if_req) begin
                    state_d     = ST_F_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = 32'd0;
                    mem_wstrb_d = 4'd0;
                    streak_d    = 4'd0;
                end else begin
                    streak_d    = 4'd0;
                end
            end
            ST_D_BUSY, ST_F_BUSY: begin
                if (mem_ack) begin
                    // Ack wins even on the watchdog's final cycle.
                    state_d    = ST_IDLE;
                    mem_req_d  = 1'b0;
                    wait_cnt_d = 8'd0;
                    if (owner_data_s) begin
                        d_rdata_d = mem_rdata;
                        d_valid_d = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata;
                        if_valid_d = 1'b1;
                    end
                end else if (wait_cnt_q == WAIT_LIM) begin
                    // Abort: release the owner with zero data and flag it.
                    state_d    = ST_IDLE;
                    mem_req_d  = 1'b0;
                    wait_cnt_d = 8'd0;
                    bus_err_d  = 1'b1;
                    if (owner_data_s) begin
                        d_rdata_d = 32'd0;
                        d_valid_d = 1'b1;
                    end else begin
                        if_rdata_d = 32'd0;
                        if_valid_d = 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                mem_req_d  = 1'b0;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_wstrb_q <= 4'd0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            streak_q    <= 4'd0;
            wait_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
            bus_err_q   <= bus_err_d;
            streak_q    <= streak_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_valid  = if_valid_q;
    assign d_valid   = d_valid_q;
    assign bus_err   = bus_err_q;

    // Stalls release in the completion cycle so the stage can advance.
    assign stall_f = if_req & ~if_valid_q;
    assign stall_m = d_req  & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by random
// traffic. A transaction-level model predicts each grant and each completion
// and queues them; an independent monitor compares the DUT against the queues.
module tb_mem_port_arbiter;

    localparam int MAXB = 4;
    localparam int TMO  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic [3:0]  d_wstrb = 4'd0;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_valid, d_valid, mem_req, mem_we, stall_f, stall_m, bus_err;
    logic [3:0]  mem_wstrb;

    mem_port_arbiter #(.MAX_DATA_BURST(MAXB), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_f(stall_f), .stall_m(stall_m), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_data;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          due;
    } gnt_t;

    typedef struct {
        bit          is_data;
        logic [31:0] rdata;
        bit          err;
        int          due;
    } resp_t;

    gnt_t  gnt_q[$];
    resp_t exp_q[$];

    int checks = 0;
    int failures = 0;

    // Reference model state (transaction level)
    bit          m_busy = 1'b0;
    bit          m_owner_data = 1'b0;
    int          m_cycles = 0;
    int          m_ack_at = 0;
    int          m_bypass = 0;
    bit          m_err = 1'b0;
    int          force_lat = 1;
    logic [31:0] dir_rdata = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
    endtask

    // Model: predicts grants in idle cycles and completions in busy cycles.
    always begin
        gnt_t  g;
        resp_t r;
        int    sel;
        @(negedge clk);
        #1;
        if (rst) begin
            m_busy = 1'b0; m_bypass = 0; m_err = 1'b0;
            exp_q.delete(); gnt_q.delete();
        end else if (m_busy) begin
            m_cycles++;
            if (mem_ack) begin
                r.is_data = m_owner_data; r.rdata = mem_rdata; r.err = m_err; r.due = cyc + 1;
                exp_q.push_back(r);
                m_busy = 1'b0;
            end else if (m_cycles == TMO) begin
                m_err = 1'b1;
                r.is_data = m_owner_data; r.rdata = 32'd0; r.err = 1'b1; r.due = cyc + 1;
                exp_q.push_back(r);
                m_busy = 1'b0;
            end
        end else if (d_req || if_req) begin
            // Data wins unless fetch has already been passed over MAXB times.
            if (d_req && (!if_req || m_bypass < MAXB)) begin
                g.is_data = 1'b1; g.we = d_we; g.addr = d_addr; g.wdata = d_wdata;
                g.wstrb = d_we ? d_wstrb : 4'd0;
                m_bypass = if_req ? m_bypass + 1 : 0;
            end else begin
                g.is_data = 1'b0; g.we = 1'b0; g.addr = if_addr; g.wdata = 32'd0;
                g.wstrb = 4'd0;
                m_bypass = 0;
            end
            g.due = cyc + 1;
            gnt_q.push_back(g);
            m_owner_data = g.is_data;
            m_busy = 1'b1;
            m_cycles = 0;
            if (force_lat >= 0) begin
                m_ack_at = force_lat;
            end else begin
                sel = int'($urandom_range(0, 15));
                if (sel < 10)      m_ack_at = int'($urandom_range(1, 4));
                else if (sel < 12) m_ack_at = TMO;
                else if (sel < 13) m_ack_at = 0;
                else               m_ack_at = int'($urandom_range(5, TMO - 1));
            end
        end else begin
            m_bypass = 0;
        end
    end

    bit   hold_active = 1'b0;
    bit   rst_seen = 1'b0;
    gnt_t cur;

    task automatic cmp_grant(input gnt_t g, input string tag);
        chk({tag, "_we"}, 32'(mem_we), 32'(g.we));
        chk({tag, "_addr"}, mem_addr, g.addr);
        if (g.is_data) chk({tag, "_wdata"}, mem_wdata, g.wdata);
        chk({tag, "_wstrb"}, 32'(mem_wstrb), 32'(g.wstrb));
    endtask

    // Monitor: compares DUT outputs against queued expectations.
    always @(negedge clk) begin
        resp_t r;
        if (rst_seen) begin
            chk("rst_ctrl", {27'd0, mem_req, mem_we, if_valid, d_valid, bus_err}, 32'd0);
            chk("rst_mem_addr", mem_addr, 32'd0);
            chk("rst_mem_wdata", mem_wdata, 32'd0);
            chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
            chk("rst_if_rdata", if_rdata, 32'd0);
            chk("rst_d_rdata", d_rdata, 32'd0);
            hold_active = 1'b0;
        end else begin
            if (if_valid || d_valid) begin
                chk("valid_exclusive", 32'(if_valid & d_valid), 32'd0);
                chk("mem_req_low_on_valid", 32'(mem_req), 32'd0);
                if (exp_q.size() == 0) begin
                    fail_evt("unexpected_valid");
                end else begin
                    r = exp_q.pop_front();
                    chk("valid_owner_data", 32'(d_valid), 32'(r.is_data));
                    chk("valid_cycle", cyc, r.due);
                    chk("rdata", r.is_data ? d_rdata : if_rdata, r.rdata);
                    chk("bus_err_at_valid", 32'(bus_err), 32'(r.err));
                end
                hold_active = 1'b0;
            end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                fail_evt("missing_valid");
                void'(exp_q.pop_front());
            end
            if (mem_req && !hold_active) begin
                if (gnt_q.size() == 0) begin
                    fail_evt("unexpected_mem_req");
                end else begin
                    cur = gnt_q.pop_front();
                    hold_active = 1'b1;
                    chk("grant_cycle", cyc, cur.due);
                    cmp_grant(cur, "grant");
                end
            end else if (hold_active) begin
                chk("mem_req_held", 32'(mem_req), 32'd1);
                cmp_grant(cur, "hold");
            end else if (gnt_q.size() > 0 && gnt_q[0].due < cyc) begin
                fail_evt("missing_grant");
                void'(gnt_q.pop_front());
            end
        end
        chk("stall_f", 32'(stall_f), 32'(if_req & ~if_valid));
        chk("stall_m", 32'(stall_m), 32'(d_req & ~d_valid));
        chk("bus_err", 32'(bus_err), 32'(m_err));
        if (rst) hold_active = 1'b0;
        rst_seen = rst;
    end

    // One clock of stimulus; memory acks come from the model's chosen latency.
    task automatic step(input bit rnd);
        @(posedge clk);
        #1;
        mem_ack = m_busy && ((m_cycles + 1) == m_ack_at);
        if (rnd) begin
            mem_rdata = $urandom();
            if (!m_busy && $urandom_range(0, 3) == 0) mem_ack = 1'b1;
            if (if_valid || !if_req) begin
                if ($urandom_range(0, 3) != 0) begin
                    if_req = 1'b1; if_addr = $urandom();
                end else begin
                    if_req = 1'b0;
                end
            end
            if (d_valid || !d_req) begin
                if ($urandom_range(0, 3) != 0) begin
                    d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom();
                    d_wdata = $urandom(); d_wstrb = 4'($urandom_range(0, 15));
                end else begin
                    d_req = 1'b0;
                end
            end
        end else begin
            mem_rdata = dir_rdata;
        end
    endtask

    // Run until both requesters have been served, dropping each on its valid.
    task automatic drain(input int max);
        int n = 0;
        while ((if_req || d_req) && n < max) begin
            step(1'b0);
            if (if_valid) if_req = 1'b0;
            if (d_valid) d_req = 1'b0;
            n++;
        end
        if (if_req || d_req) begin
            fail_evt("drain_timeout");
            if_req = 1'b0;
            d_req = 1'b0;
        end
        repeat (2) step(1'b0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) step(1'b0);
        rst = 1'b0;
        step(1'b0);

        // Load with a 3-cycle memory
        force_lat = 3; dir_rdata = 32'h1234_5678;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0100; d_wdata = 32'h0; d_wstrb = 4'hF;
        drain(20);

        // Store: strobes and data held until ack
        force_lat = 3; dir_rdata = 32'h0BAD_F00D;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0204; d_wdata = 32'hAABB_CCDD;
        d_wstrb = 4'b1100;
        drain(20);

        // Simultaneous continuous requests, single-cycle memory
        force_lat = 1; dir_rdata = 32'h5555_AAAA;
        if_req = 1'b1; if_addr = 32'h0000_1000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000;
        repeat (30) step(1'b0);
        drain(40);

        // Ack lands on the final watchdog cycle: normal completion
        force_lat = TMO; dir_rdata = 32'hCAFE_0001;
        if_req = 1'b1; if_addr = 32'h0000_0300;
        drain(30);

        // Fetch with no ack: abort with zero data, sticky error
        force_lat = 0; dir_rdata = 32'hFFFF_FFFF;
        if_req = 1'b1; if_addr = 32'h0000_0500;
        drain(30);
        repeat (3) step(1'b0);
        chk("bus_err_sticky", 32'(bus_err), 32'd1);

        // Reset while a load is in flight, then a stray ack
        force_lat = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0600;
        repeat (4) step(1'b0);
        rst = 1'b1; d_req = 1'b0;
        step(1'b0);
        rst = 1'b0; mem_ack = 1'b1;
        step(1'b0);
        force_lat = 2; dir_rdata = 32'h0102_0304;
        if_req = 1'b1; if_addr = 32'h0000_0700;
        drain(20);

        // Random traffic
        force_lat = -1;
        repeat (3000) step(1'b1);
        drain(100);
        repeat (3) step(1'b0);
        chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("grant_queue_empty", 32'(gnt_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
